sha1_msg_fetch: RTL and testbench
=================================

Name: sha1_msg_fetch

Overview:
- Avalon-MM read master on the second port (s2) of the dual-port system memory; the first port stays with the Nios/host, which loads padded message blocks.
- Walks a contiguous region of 512-bit message blocks (16 × 32-bit words each) and streams the words, in address order, to the SHA-1 core's message-schedule input over a valid/ready interface.
- Decouples memory read latency from core back-pressure with a small FIFO.

Parameters:
- ADDR_W, 13, memory word-address width.
- MEM_WORDS, 8000, number of implemented memory words; used for the range check.
- FIFO_DEPTH, 4, output buffer depth in words; power of two, at least 2.

Ports:
- clk  in  1  system clock; same clock as memory port s2.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  word address of first word of block 0.
- num_blocks  in  8  number of 16-word blocks to fetch.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse: run complete or rejected.
- err  out  1  one-cycle pulse, coincident with done, on range rejection.
- mem_address  out  ADDR_W  to s2 address.
- mem_chipselect  out  1  to s2 chipselect.
- mem_write  out  1  tied 0.
- mem_byteenable  out  4  tied 4'hF.
- mem_readdata  in  32  from s2; valid exactly 1 cycle after the chipselect cycle (address registered, output unregistered).
- out_valid  out  1  stream word valid.
- out_ready  in  1  core accepts word.
- out_data  out  32  message word.
- out_last_word  out  1  high with word 15 of each block.
- out_last_block  out  1  high with every word of the final block.

Behaviour:
- Reset (async, active-high): FSM to IDLE; FIFO empty; all counters 0. Outputs: busy=0, done=0, err=0, mem_chipselect=0, mem_address=0, out_valid=0, out_data=0, out_last_word=0, out_last_block=0.
- Reset asserted mid-run: the run is abandoned immediately. No done pulse is generated and FIFO contents are discarded.
- Total words T = 16·num_blocks (12-bit counter). Issue counter I and emit counter E count from 0.
- IDLE, start=1:
  - num_blocks=0 → go to FINISH; no memory access.
  - base_addr + T > MEM_WORDS (computed at 14 bits, no wrap) → go to FINISH with err flagged; no memory access.
  - Otherwise latch base and T, busy=1, go to FETCH.
- FETCH:
  - Issue a read (mem_chipselect=1, mem_address=base+I) when I<T and fifo_count + inflight < FIFO_DEPTH; then I++.
  - inflight is 1 during the cycle after an issue, else 0.
  - Readdata is written into the FIFO in the cycle after its issue.
  - Go to DRAIN when I=T and the final read has landed.
- DRAIN: when E=T (last word handshaken), go to FINISH.
- FINISH: done=1 for one cycle (err=1 as well if rejected); busy=0 in this same cycle; next state IDLE. A start in the FINISH cycle is ignored.
- start while busy: ignored; latched parameters do not change.
- Output handshake:
  - A word transfers on out_valid & out_ready; E++.
  - out_valid = FIFO non-empty. out_data and flags are stable while out_valid=1 and out_ready=0.
  - Flags travel with each word: out_last_word = (E[3:0]==15); out_last_block = (E ≥ T−16).
- Latency: start accepted at cycle 0 → first chipselect at cycle 1 → first word written to FIFO at cycle 2 → out_valid=1 at cycle 3.
- Throughput: with out_ready held at 1, one word per cycle sustained; no bubbles after the first word.
- The FIFO never overflows or underflows. Simultaneous push and pop leave fifo_count unchanged.
- Addresses never exceed MEM_WORDS−1 because of the start-time range check.

Test Plan:
- base=0x0100, num_blocks=1, memory preloaded with word[i]=i, out_ready=1 → chipselect cycles 1–16 with addresses 0x0100..0x010F; out_data 0x100..0x10F on cycles 3–18; out_last_word and out_last_block high on the 16th word; done and busy=0 on cycle 19.
- base=0, num_blocks=3, out_ready toggling 1/0 each cycle → exactly 48 words in order; out_last_word on words 15, 31 and 47; out_last_block on words 32–47; no duplicated or lost words; chipselect stalls whenever FIFO_DEPTH is reached.
- num_blocks=0 → done pulse at cycle 1 with err=0; no chipselect. Then base=7985, num_blocks=1 (7985+16 > 8000) → done and err together at cycle 1; no chipselect. base=7984, num_blocks=1 → accepted; last address 7999.
- out_ready held 0 for 20 cycles after start (base=0x200, num_blocks=1) → exactly 4 reads issued; out_data stays 0x200 throughout; after out_ready rises, the remaining 12 words follow without bubbles.
- Second start pulse mid-run → ignored; the run completes with the original parameters and a single done pulse.
- reset asserted at cycle 8 of a 2-block run → all outputs 0 immediately, no done pulse; a new start afterwards runs correctly from an empty FIFO.

Source files
------------

// File: rtl/sha1_msg_fetch.sv
// Message-block fetch engine: reads 16-word SHA-1 blocks from dual-port memory port s2
// and streams them in address order to the core through a small decoupling FIFO.
module sha1_msg_fetch #(
  parameter int ADDR_W     = 13,
  parameter int MEM_WORDS  = 8000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_blocks,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [31:0]       mem_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last_word,
  output logic              out_last_block
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CHK_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_r;
  logic [11:0]       t_total;
  logic [11:0]       i_cnt;
  logic [11:0]       e_cnt;
  logic              err_r;
  logic              inflight_p1;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    occupancy;

  logic [11:0]       t_req;
  logic [CHK_W-1:0]  end_req;
  logic              range_bad;
  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic [11:0]       e_cnt_nxt;

  function automatic logic range_exceeded(input logic [ADDR_W-1:0] base, input logic [11:0] words);
    logic [CHK_W-1:0] last_excl;
    last_excl = CHK_W'(base) + CHK_W'(words);
    return last_excl > CHK_W'(MEM_WORDS);
  endfunction

  assign t_req     = {num_blocks, 4'h0};
  assign end_req   = CHK_W'(base_addr) + CHK_W'(t_req);
  assign range_bad = range_exceeded(base_addr, t_req);

  // Reservation counts the read still on the bus so the FIFO can never overflow.
  assign occupancy = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight_p1};
  assign push      = inflight_p1;
  assign pop       = out_valid & out_ready;
  assign e_cnt_nxt = e_cnt + {11'd0, pop};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if ((num_blocks == 8'd0) || range_bad) begin
            state_nxt = FINISH;
          end else begin
            accept    = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        issue = (i_cnt != t_total) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
        // Once every read is issued, the last one lands in this cycle.
        if (i_cnt == t_total) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (e_cnt_nxt == t_total) state_nxt = FINISH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: read issued on s2, data returns on mem_readdata next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      base_r      <= '0;
      t_total     <= '0;
      i_cnt       <= '0;
      e_cnt       <= '0;
      err_r       <= 1'b0;
      inflight_p1 <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      inflight_p1 <= issue;
      if (state == IDLE && start) err_r <= (num_blocks != 8'd0) && range_bad;
      if (accept) begin
        base_r  <= base_addr;
        t_total <= t_req;
        i_cnt   <= '0;
        e_cnt   <= '0;
      end else begin
        if (issue) i_cnt <= i_cnt + 12'd1;
        e_cnt <= e_cnt_nxt;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Stage p1: returned word captured into the output FIFO.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_readdata;
  end

  assign busy           = (state == FETCH) || (state == DRAIN);
  assign done           = (state == FINISH);
  assign err            = (state == FINISH) && err_r;
  assign mem_chipselect = issue;
  assign mem_address    = issue ? (base_r + ADDR_W'(i_cnt)) : '0;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;

  // The head word is always word E of the run, so flags derive from the emit counter.
  assign out_valid      = (fifo_cnt != '0);
  assign out_data       = out_valid ? fifo_mem[rd_ptr] : 32'd0;
  assign out_last_word  = out_valid && (e_cnt[3:0] == 4'hF);
  assign out_last_block = out_valid && (e_cnt >= (t_total - 12'd16));

endmodule

// File: tb/tb_sha1_msg_fetch.sv
// Scoreboard bench for sha1_msg_fetch: behavioural s2 memory, expected words queued at
// start and popped on each output handshake, plus timing and range-check checks.
module tb_sha1_msg_fetch;

  localparam int ADDR_W    = 13;
  localparam int MEM_WORDS = 8000;
  localparam int DEPTH     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [7:0]        num_blocks = '0;
  logic              busy, done, err;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_readdata = 32'd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_data;
  logic              out_last_word, out_last_block;

  sha1_msg_fetch #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
    .busy(busy), .done(done), .err(err),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last_word(out_last_word), .out_last_block(out_last_block)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_WORDS];

  // s2 model: address registered, data valid the cycle after chipselect, garbage otherwise.
  always @(posedge clk) begin
    if (mem_chipselect && int'(mem_address) < MEM_WORDS) mem_readdata <= mem[mem_address];
    else mem_readdata <= 32'hDEADBEEF;
  end

  typedef struct packed {
    logic [31:0] d;
    logic        lw;
    logic        lb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_vec = 0, n_err = 0;
  int cyc = 0, t0 = 0, rel = 0;
  int run_base = 0;
  int cs_cnt = 0, pop_cnt = 0, first_cs = -1, last_cs = -1;
  int first_word = -1, last_word = -1, done_cnt = 0, done_rel = -1;
  int last_addr = -1;
  logic done_err = 1'b0;
  bit bubble_chk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      rel = cyc - t0;
      if (mem_chipselect) begin
        chk("rd_addr", 32'(mem_address), 32'(run_base + cs_cnt));
        chk("fifo_room", 32'((cs_cnt - pop_cnt) < DEPTH), 32'd1);
        cs_cnt++;
        if (first_cs < 0) first_cs = rel;
        last_cs = rel;
        last_addr = int'(mem_address);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'd1, 32'd0);
        end else if (out_ready) begin
          mon_e = exp_q.pop_front();
          chk("data", out_data, mon_e.d);
          chk("last_word", 32'(out_last_word), 32'(mon_e.lw));
          chk("last_block", 32'(out_last_block), 32'(mon_e.lb));
          if (bubble_chk && last_word >= 0) chk("bubble", 32'(rel - last_word), 32'd1);
          if (first_word < 0) first_word = rel;
          last_word = rel;
          pop_cnt++;
        end else begin
          chk("hold_data", out_data, exp_q[0].d);
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
        done_err = err;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic reset_check(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
    chk({tag, "_addr"}, 32'(mem_address), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_lw"}, 32'(out_last_word), 32'd0);
    chk({tag, "_lb"}, 32'(out_last_block), 32'd0);
  endtask

  task automatic start_run(input int base, input int nb);
    exp_t e;
    @(posedge clk); #1;
    run_base = base;
    cs_cnt = 0; pop_cnt = 0; first_cs = -1; last_cs = -1; first_word = -1; last_word = -1;
    done_cnt = 0; done_rel = -1; done_err = 1'b0; last_addr = -1;
    if (nb != 0 && base + 16 * nb <= MEM_WORDS) begin
      for (int i = 0; i < 16 * nb; i++) begin
        e.d  = mem[base + i];
        e.lw = ((i % 16) == 15);
        e.lb = (i >= 16 * nb - 16);
        exp_q.push_back(e);
      end
    end
    base_addr = ADDR_W'(base);
    num_blocks = 8'(nb);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_wait(input int max_cyc, input bit toggle);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      n++;
    end
    if (done_cnt == 0) chk("timeout", 32'd0, 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'(i);
    repeat (3) @(posedge clk);
    #1;
    reset_check("por");
    reset = 1'b0;

    // Single block, continuous ready: exact latency and cycle positions.
    bubble_chk = 1'b1;
    start_run(32'h100, 1);
    run_wait(100, 1'b0);
    chk("t1_first_cs", 32'(first_cs), 32'd1);
    chk("t1_last_cs", 32'(last_cs), 32'd16);
    chk("t1_cs_cnt", 32'(cs_cnt), 32'd16);
    chk("t1_last_addr", 32'(last_addr), 32'h10F);
    chk("t1_first_word", 32'(first_word), 32'd3);
    chk("t1_last_word", 32'(last_word), 32'd18);
    chk("t1_done_rel", 32'(done_rel), 32'd19);
    chk("t1_err", 32'(done_err), 32'd0);

    // Three blocks with toggling ready.
    bubble_chk = 1'b0;
    start_run(0, 3);
    run_wait(400, 1'b1);
    chk("t2_cs_cnt", 32'(cs_cnt), 32'd48);
    chk("t2_pop_cnt", 32'(pop_cnt), 32'd48);

    // Zero blocks and range checks.
    start_run(0, 0);
    run_wait(20, 1'b0);
    chk("t3a_done_rel", 32'(done_rel), 32'd1);
    chk("t3a_err", 32'(done_err), 32'd0);
    chk("t3a_cs", 32'(cs_cnt), 32'd0);
    start_run(7985, 1);
    run_wait(20, 1'b0);
    chk("t3b_done_rel", 32'(done_rel), 32'd1);
    chk("t3b_err", 32'(done_err), 32'd1);
    chk("t3b_cs", 32'(cs_cnt), 32'd0);
    bubble_chk = 1'b1;
    start_run(7984, 1);
    run_wait(100, 1'b0);
    chk("t3c_cs", 32'(cs_cnt), 32'd16);
    chk("t3c_last_addr", 32'(last_addr), 32'd7999);
    chk("t3c_err", 32'(done_err), 32'd0);

    // Back-pressure: ready low for 20 cycles.
    bubble_chk = 1'b0;
    out_ready = 1'b0;
    start_run(32'h200, 1);
    repeat (19) @(posedge clk);
    #1;
    chk("t4_cs_stall", 32'(cs_cnt), 32'd4);
    chk("t4_no_pop", 32'(pop_cnt), 32'd0);
    chk("t4_head", out_data, 32'h200);
    out_ready = 1'b1;
    bubble_chk = 1'b1;
    run_wait(100, 1'b0);
    chk("t4_pop_cnt", 32'(pop_cnt), 32'd16);

    // Second start while busy must be ignored.
    start_run(32'h80, 2);
    repeat (5) @(posedge clk);
    #1;
    base_addr = ADDR_W'(32'h400);
    num_blocks = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_wait(200, 1'b0);
    chk("t5_cs_cnt", 32'(cs_cnt), 32'd32);
    chk("t5_last_addr", 32'(last_addr), 32'h80 + 32'd31);

    // Reset mid-run, then a fresh run.
    start_run(32'h300, 2);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    reset_check("mid");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    start_run(32'h40, 1);
    run_wait(100, 1'b0);
    chk("t6_cs_cnt", 32'(cs_cnt), 32'd16);
    chk("t6_first_word", 32'(first_word), 32'd3);
    chk("t6_done_rel", 32'(done_rel), 32'd19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
